// File: rtl/block_serial_subtractor_pkg.sv
// Shared arithmetic definitions: FSM encodings, clog2 and the slice-width legality check.
`define BSS_ASSERT_DIVISIBLE(w, b) \
  if (((w) % (b)) != 0) begin : g_width_check \
    $error("WIDTH must be a multiple of BLOCK_WIDTH"); \
  end

package block_serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = 32'(i + 1);
    end
    return r;
  endfunction

endpackage

// File: rtl/block_serial_subtractor_borrow_bypass_block.sv
// One slice of a - b - borrow with a bypass path when every bit propagates.
module borrow_bypass_block #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iBw,
  output logic [WIDTH-1:0] oD,
  output logic             oBw
);

  logic [WIDTH:0]   chain;
  logic [WIDTH-1:0] p;

  always_comb begin
    chain[0] = iBw;
    for (int i = 0; i < WIDTH; i++) begin
      p[i]         = ~(iA[i] ^ iB[i]);
      oD[i]        = iA[i] ^ iB[i] ^ chain[i];
      chain[i + 1] = (~iA[i] & iB[i]) | (p[i] & chain[i]);
    end
    // A fully propagating slice passes the incoming borrow straight through.
    oBw = (&p) ? iBw : chain[WIDTH];
  end

endmodule

// File: rtl/block_serial_subtractor.sv
// Serial unsigned subtractor: one BLOCK_WIDTH slice per clock, LSB slice first, valid/ready on both sides.
module block_serial_subtractor
  import block_serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned BLOCK_WIDTH = 4
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             iBw,
  output logic             oValid,
  input  logic             iReady,
  output logic [WIDTH-1:0] oD,
  output logic             oBw,
  output logic             oZ
);

  localparam int unsigned NBLK = WIDTH / BLOCK_WIDTH;
  localparam int unsigned CW   = (NBLK > 1) ? clog2(NBLK) : 1;

  `BSS_ASSERT_DIVISIBLE(WIDTH, BLOCK_WIDTH)

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [WIDTH-1:0]       a_q;
  logic [WIDTH-1:0]       b_q;
  logic                   bw_q;
  logic [WIDTH-1:0]       work;
  logic [WIDTH-1:0]       work_nxt;
  logic [BLOCK_WIDTH-1:0] a_s;
  logic [BLOCK_WIDTH-1:0] b_s;
  logic [BLOCK_WIDTH-1:0] d_s;
  logic                   bw_s;
  logic                   last;

  // Counter-selected operand slice.
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int k = 0; k < NBLK; k++) begin
      if (cnt == CW'(k)) begin
        a_s = a_q[k*BLOCK_WIDTH +: BLOCK_WIDTH];
        b_s = b_q[k*BLOCK_WIDTH +: BLOCK_WIDTH];
      end
    end
  end

  borrow_bypass_block #(
    .WIDTH(BLOCK_WIDTH)
  ) u_slice (
    .iA (a_s),
    .iB (b_s),
    .iBw(bw_q),
    .oD (d_s),
    .oBw(bw_s)
  );

  // Merge the current slice into the working result.
  always_comb begin
    work_nxt = work;
    for (int k = 0; k < NBLK; k++) begin
      if (cnt == CW'(k)) work_nxt[k*BLOCK_WIDTH +: BLOCK_WIDTH] = d_s;
    end
  end

  assign last = (cnt == CW'(NBLK - 1));

  // Outputs only update on completion, so an aborted run never leaks a partial result.
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      bw_q   <= 1'b0;
      work   <= '0;
      oD     <= '0;
      oBw    <= 1'b0;
      oZ     <= 1'b0;
      oValid <= 1'b0;
      oReady <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iValid) begin
            a_q    <= iA;
            b_q    <= iB;
            bw_q   <= iBw;
            cnt    <= '0;
            oReady <= 1'b0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          work <= work_nxt;
          bw_q <= bw_s;
          cnt  <= cnt + CW'(1);
          if (last) begin
            oD     <= work_nxt;
            oBw    <= bw_s;
            oZ     <= (work_nxt == '0);
            oValid <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (iReady) begin
            oValid <= 1'b0;
            oReady <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: begin
          oValid <= 1'b0;
          oReady <= 1'b1;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_serial_subtractor.sv
// Directed-vector and random bench for block_serial_subtractor (16-bit, 4-bit slices).
module tb_block_serial_subtractor;

  logic        iClk;
  logic        iRstN;
  logic        iValid;
  logic        oReady;
  logic [15:0] iA;
  logic [15:0] iB;
  logic        iBw;
  logic        oValid;
  logic        iReady;
  logic [15:0] oD;
  logic        oBw;
  logic        oZ;

  int checks = 0;
  int errors = 0;

  block_serial_subtractor #(
    .WIDTH(16),
    .BLOCK_WIDTH(4)
  ) dut (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iValid(iValid),
    .oReady(oReady),
    .iA    (iA),
    .iB    (iB),
    .iBw   (iBw),
    .oValid(oValid),
    .iReady(iReady),
    .oD    (oD),
    .oBw   (oBw),
    .oZ    (oZ)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bw;
    logic [15:0] d;
    logic        bwo;
    logic        z;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Present a request at the current point (#1 after an edge) and wait for oValid.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bw,
                        output int lat);
    iA     = a;
    iB     = b;
    iBw    = bw;
    iValid = 1'b1;
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    iA     = ~a;
    iB     = ~b;
    iBw    = ~bw;
    lat    = 0;
    while (!oValid && lat < 20) begin
      @(posedge iClk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result();
    iReady = 1'b1;
    @(posedge iClk);
    #1;
    iReady = 1'b0;
  endtask

  vec_t        vecs[9];
  int          lat;
  logic [15:0] hold_d;
  logic        hold_bw;
  logic        hold_z;
  logic [16:0] full;
  logic [15:0] ra;
  logic [15:0] rb;
  logic        rbw;

  initial begin
    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[3] = '{16'h5555, 16'h5554, 1'b1, 16'h0000, 1'b0, 1'b1};
    vecs[4] = '{16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[5] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[6] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0};
    vecs[7] = '{16'h00F0, 16'h0F00, 1'b0, 16'hF1F0, 1'b1, 1'b0};
    vecs[8] = '{16'h1000, 16'h0FFF, 1'b1, 16'h0000, 1'b0, 1'b1};

    iRstN  = 1'b0;
    iValid = 1'b0;
    iReady = 1'b0;
    iA     = 16'hDEAD;
    iB     = 16'hBEEF;
    iBw    = 1'b1;
    repeat (3) @(posedge iClk);
    #1;
    chk("reset_ovalid", 32'(oValid), 32'd0);
    chk("reset_oready", 32'(oReady), 32'd1);
    chk("reset_od",     32'(oD),     32'h0);
    chk("reset_obw",    32'(oBw),    32'd0);
    chk("reset_oz",     32'(oZ),     32'd0);
    iRstN = 1'b1;
    @(posedge iClk);
    #1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("v%0d_ready", i), 32'(oReady), 32'd1);
      run_op(vecs[i].a, vecs[i].b, vecs[i].bw, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      chk($sformatf("v%0d_od", i),  32'(oD),  32'(vecs[i].d));
      chk($sformatf("v%0d_obw", i), 32'(oBw), 32'(vecs[i].bwo));
      chk($sformatf("v%0d_oz", i),  32'(oZ),  32'(vecs[i].z));
      release_result();
      chk($sformatf("v%0d_release_valid", i), 32'(oValid), 32'd0);
    end

    // Backpressure with a stray request pulse while DONE
    run_op(16'h1234, 16'h0234, 1'b0, lat);
    chk("bp_valid_up", 32'(oValid), 32'd1);
    hold_d  = oD;
    hold_bw = oBw;
    hold_z  = oZ;
    chk("bp_od_first", 32'(hold_d), 32'h1000);
    for (int c = 0; c < 5; c++) begin
      iA     = 16'hAAAA;
      iB     = 16'h1111;
      iValid = (c % 2 == 0);
      @(posedge iClk);
      #1;
      chk($sformatf("bp%0d_od", c),     32'(oD),     32'h1000);
      chk($sformatf("bp%0d_obw", c),    32'(oBw),    32'(hold_bw));
      chk($sformatf("bp%0d_oz", c),     32'(oZ),     32'(hold_z));
      chk($sformatf("bp%0d_oready", c), 32'(oReady), 32'd0);
      chk($sformatf("bp%0d_ovalid", c), 32'(oValid), 32'd1);
    end
    // iValid together with iReady in DONE is dropped
    iValid = 1'b1;
    iReady = 1'b1;
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    iReady = 1'b0;
    chk("bp_rel_ovalid", 32'(oValid), 32'd0);
    chk("bp_rel_oready", 32'(oReady), 32'd1);
    @(posedge iClk);
    #1;
    chk("bp_pulse_ignored", 32'(oReady), 32'd1);
    run_op(16'h0010, 16'h0001, 1'b0, lat);
    chk("bp_next_latency", 32'(lat), 32'd4);
    chk("bp_next_od",  32'(oD),  32'h000F);
    chk("bp_next_obw", 32'(oBw), 32'd0);
    release_result();

    // Reset asserted on the second RUN cycle
    iA     = 16'h0F0F;
    iB     = 16'h0001;
    iBw    = 1'b0;
    iValid = 1'b1;
    @(posedge iClk);
    #1;
    iValid = 1'b0;
    @(posedge iClk);
    #1;
    iRstN = 1'b0;
    @(posedge iClk);
    #1;
    iRstN = 1'b1;
    chk("midrst_ovalid", 32'(oValid), 32'd0);
    chk("midrst_oready", 32'(oReady), 32'd1);
    chk("midrst_od",     32'(oD),     32'h0);
    chk("midrst_obw",    32'(oBw),    32'd0);
    chk("midrst_oz",     32'(oZ),     32'd0);
    repeat (6) begin
      @(posedge iClk);
      #1;
    end
    chk("midrst_no_result", 32'(oValid), 32'd0);
    run_op(16'hFFFF, 16'h8000, 1'b0, lat);
    chk("midrst_next_latency", 32'(lat), 32'd4);
    chk("midrst_next_od",  32'(oD),  32'h7FFF);
    chk("midrst_next_obw", 32'(oBw), 32'd0);
    release_result();

    // Random vectors against a 17-bit reference subtract
    for (int n = 0; n < 1000; n++) begin
      ra   = 16'($urandom);
      rb   = (n % 8 == 0) ? ra : 16'($urandom);
      rbw  = 1'($urandom);
      full = {1'b0, ra} - {1'b0, rb} - 17'(rbw);
      run_op(ra, rb, rbw, lat);
      chk($sformatf("rnd%0d_od a=%h b=%h bw=%0d", n, ra, rb, rbw), 32'(oD), 32'(full[15:0]));
      chk($sformatf("rnd%0d_obw", n), 32'(oBw), 32'(full[16]));
      chk($sformatf("rnd%0d_oz", n), 32'(oZ), 32'(full[15:0] == 16'h0));
      release_result();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
